mmio_io_responder: RTL and testbench

Memory-mapped I/O responder on the processor's data-memory bus for the 0xFFxx device window. It answers CPU loads and stores to the keys, switches, HEX display, red and green LEDs, and an interval timer. It synchronizes and debounces the board inputs, keeps sticky event flags, and drives the board outputs from registers. It sits beside MemArray: the CPU's read mux selects `DOUT` when `SEL` is high.

---
 rtl/mmio_io_responder_if.sv | 13 +
 rtl/mmio_io_responder.sv | 152 +++++++++++++++
 tb/tb_mmio_io_responder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_responder_if.sv
// CPU data-bus slice seen by the 0xFFxx device-window responder.
interface mmio_io_responder_if #(
  parameter int unsigned DBITS = 16
);
  logic [15:0]      ADDR;
  logic [DBITS-1:0] DIN;
  logic             WE;
  logic [DBITS-1:0] DOUT;
  logic             SEL;

  modport master (output ADDR, DIN, WE, input DOUT, SEL);
  modport slave  (input ADDR, DIN, WE, output DOUT, SEL);
endinterface

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: debounced keys/switches with sticky flags,
// HEX/LED output registers and a prescaled interval timer.
module mmio_io_responder #(
  parameter int unsigned DBITS    = 16,
  parameter int unsigned DEBOUNCE = 500000,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  mmio_io_responder_if.slave  bus,
  input  logic [3:0]          KEY,
  input  logic [9:0]          SW,
  output logic [15:0]         HEX,
  output logic [9:0]          LEDR,
  output logic [7:0]          LEDG
);
  localparam int unsigned NIN  = 13;  // SW[9:0] at 0..9, KEY[3:1] at 10..12
  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [NIN-1:0] IN_RST = {3'b111, 10'b0};

  localparam logic [15:0] A_KDATA = 16'hFFF0;
  localparam logic [15:0] A_SDATA = 16'hFFF2;
  localparam logic [15:0] A_KCTRL = 16'hFFF4;
  localparam logic [15:0] A_SCTRL = 16'hFFF6;
  localparam logic [15:0] A_HEXR  = 16'hFFF8;
  localparam logic [15:0] A_LEDRR = 16'hFFFA;
  localparam logic [15:0] A_LEDGR = 16'hFFFC;
  localparam logic [15:0] A_TCNT  = 16'hFFE0;
  localparam logic [15:0] A_TLIM  = 16'hFFE2;
  localparam logic [15:0] A_TCTL  = 16'hFFE4;

  logic [NIN-1:0]  raw, sync1, sync2, deb, upd;
  logic [DB_W-1:0] deb_cnt [NIN];
  logic [2:0]      press, kflag;
  logic            kovr, schg, sw_chg;
  logic [15:0]     hex_q, tcnt, tlim, rdata;
  logic [9:0]      ledr_q;
  logic [7:0]      ledg_q;
  logic [PS_W-1:0] pre;
  logic            t_en, t_rdy, t_ovr, run, tick, hit;
  logic            wr_kctrl, wr_sctrl, wr_hex, wr_ledr, wr_ledg, wr_tcnt, wr_tlim, wr_tctl;
  logic            unused_key0;

  // KEY0 is the clock key and is handled elsewhere on the board.
  assign unused_key0 = KEY[0];
  assign raw = {KEY[3:1], SW};

  // A bit updates after DEBOUNCE consecutive cycles of disagreeing with its debounced value.
  always_comb begin
    upd = '0;
    for (int i = 0; i < NIN; i++) begin
      upd[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DB_W'(DEBOUNCE - 1));
    end
  end

  assign press  = upd[12:10] & ~sync2[12:10];
  assign sw_chg = |upd[9:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= IN_RST;
      sync2 <= IN_RST;
      deb   <= IN_RST;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb ^ upd;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == deb[i] || upd[i]) deb_cnt[i] <= '0;
        else                              deb_cnt[i] <= deb_cnt[i] + DB_W'(1);
      end
    end
  end

  assign wr_kctrl = bus.WE && (bus.ADDR == A_KCTRL);
  assign wr_sctrl = bus.WE && (bus.ADDR == A_SCTRL);
  assign wr_hex   = bus.WE && (bus.ADDR == A_HEXR);
  assign wr_ledr  = bus.WE && (bus.ADDR == A_LEDRR);
  assign wr_ledg  = bus.WE && (bus.ADDR == A_LEDGR);
  assign wr_tcnt  = bus.WE && (bus.ADDR == A_TCNT);
  assign wr_tlim  = bus.WE && (bus.ADDR == A_TLIM);
  assign wr_tctl  = bus.WE && (bus.ADDR == A_TCTL);

  // A disabling TCTL write or a TCNT write on a tick cycle swallows that tick.
  assign run  = t_en && !(wr_tctl && !bus.DIN[0]);
  assign tick = run && !wr_tcnt && (pre == PS_W'(PRESCALE - 1));
  assign hit  = tick && (tcnt == tlim) && (tlim != 16'h0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
      tcnt   <= '0;
      tlim   <= '0;
      pre    <= '0;
      t_en   <= 1'b0;
      t_rdy  <= 1'b0;
      t_ovr  <= 1'b0;
      kflag  <= '0;
      kovr   <= 1'b0;
      schg   <= 1'b0;
    end else begin
      if (wr_hex)  hex_q  <= bus.DIN[15:0];
      if (wr_ledr) ledr_q <= bus.DIN[9:0];
      if (wr_ledg) ledg_q <= bus.DIN[7:0];
      if (wr_tlim) tlim   <= bus.DIN[15:0];
      if (wr_tctl) t_en   <= bus.DIN[0];
      if (wr_tcnt) begin
        tcnt <= bus.DIN[15:0];
        pre  <= '0;
      end else if (run) begin
        pre <= (pre == PS_W'(PRESCALE - 1)) ? '0 : pre + PS_W'(1);
        if (tick) tcnt <= hit ? 16'h0 : tcnt + 16'd1;
      end
      // Hardware sets win over write-1-clears landing in the same cycle.
      t_rdy <= (t_rdy & ~(wr_tctl & bus.DIN[1])) | hit;
      t_ovr <= (t_ovr & ~(wr_tctl & bus.DIN[2])) | (hit & t_rdy);
      kflag <= (kflag & ~({3{wr_kctrl}} & bus.DIN[3:1])) | press;
      kovr  <= (kovr & ~(wr_kctrl & bus.DIN[4])) | (|(press & kflag));
      schg  <= (schg & ~(wr_sctrl & bus.DIN[0])) | sw_chg;
    end
  end

  assign HEX  = hex_q;
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

  always_comb begin
    bus.SEL = 1'b1;
    rdata   = 16'h0;
    case (bus.ADDR)
      A_KDATA: rdata = {12'h0, deb[12:10], 1'b1};
      A_SDATA: rdata = {6'h0, deb[9:0]};
      A_KCTRL: rdata = {11'h0, kovr, kflag, 1'b0};
      A_SCTRL: rdata = {15'h0, schg};
      A_HEXR:  rdata = hex_q;
      A_LEDRR: rdata = {6'h0, ledr_q};
      A_LEDGR: rdata = {8'h0, ledg_q};
      A_TCNT:  rdata = tcnt;
      A_TLIM:  rdata = tlim;
      A_TCTL:  rdata = {13'h0, t_ovr, t_rdy, t_en};
      default: begin
        bus.SEL = 1'b0;
        rdata   = 16'hDEAD;
      end
    endcase
    bus.DOUT = DBITS'(rdata);
  end
endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder with DEBOUNCE=4, PRESCALE=3.
module tb_mmio_io_responder;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  int          n_pass = 0;
  int          n_total = 0;

  mmio_io_responder_if #(.DBITS(16)) bus ();

  mmio_io_responder #(.DBITS(16), .DEBOUNCE(4), .PRESCALE(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus),
    .KEY(KEY), .SW(SW), .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.ADDR = a;
    bus.DIN  = d;
    bus.WE   = 1'b1;
    cyc(1);
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.ADDR = a;
    #1;
    check(tag, 32'(bus.DOUT), 32'(exp));
  endtask

  initial begin
    RESET_N  = 1'b0;
    KEY      = 4'hF;
    SW       = 10'h0;
    bus.ADDR = 16'hFFF8;
    bus.DIN  = 16'hFFFF;
    bus.WE   = 1'b0;

    // Reset with stores attempted
    repeat (4) begin
      bus.WE = ~bus.WE;
      cyc(1);
    end
    bus.WE = 1'b0;
    check("rst_hex", 32'(HEX), 32'h0);
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_ledg", 32'(LEDG), 32'h0);
    RESET_N = 1'b1;
    cyc(1);
    rd("rst_kdata", 16'hFFF0, 16'h000F);
    check("sel_mapped", 32'(bus.SEL), 32'h1);
    rd("unmapped", 16'hFF00, 16'hDEAD);
    check("sel_unmapped", 32'(bus.SEL), 32'h0);
    rd("rst_tctl", 16'hFFE4, 16'h0000);

    // Stores
    wr(16'hFFF8, 16'h1234);
    wr(16'hFFFA, 16'h03FF);
    wr(16'hFFFC, 16'h00A5);
    check("hex_out", 32'(HEX), 32'h1234);
    check("ledr_out", 32'(LEDR), 32'h3FF);
    check("ledg_out", 32'(LEDG), 32'hA5);
    rd("hex_rb", 16'hFFF8, 16'h1234);
    rd("ledr_rb", 16'hFFFA, 16'h03FF);
    rd("ledg_rb", 16'hFFFC, 16'h00A5);
    wr(16'hFFFA, 16'hFFFF);
    rd("ledr_wide", 16'hFFFA, 16'h03FF);

    // Key press on KEY[2]
    KEY[2] = 1'b0;
    cyc(5);
    rd("key_cyc5", 16'hFFF0, 16'h000F);
    cyc(1);
    rd("key_cyc6", 16'hFFF0, 16'h000B);
    rd("kctrl_press", 16'hFFF4, 16'h0004);
    cyc(4);
    KEY[2] = 1'b1;
    cyc(8);
    rd("key_release", 16'hFFF0, 16'h000F);
    rd("kctrl_release", 16'hFFF4, 16'h0004);

    // Short glitch on KEY[1]
    KEY[1] = 1'b0;
    cyc(3);
    KEY[1] = 1'b1;
    cyc(8);
    rd("glitch_kdata", 16'hFFF0, 16'h000F);
    rd("glitch_kctrl", 16'hFFF4, 16'h0004);

    wr(16'hFFF4, 16'h0004);
    rd("kctrl_clear", 16'hFFF4, 16'h0000);

    // Two presses without clearing -> overrun
    KEY[2] = 1'b0;
    cyc(8);
    KEY[2] = 1'b1;
    cyc(8);
    rd("kctrl_first", 16'hFFF4, 16'h0004);
    KEY[2] = 1'b0;
    cyc(8);
    rd("kctrl_ovr", 16'hFFF4, 16'h0014);
    KEY[2] = 1'b1;
    cyc(8);
    wr(16'hFFF4, 16'h0014);
    rd("kctrl_clr_all", 16'hFFF4, 16'h0000);

    // Timer, limit 2
    wr(16'hFFE2, 16'h0002);
    wr(16'hFFE4, 16'h0001);
    cyc(2);
    rd("tcnt_pre", 16'hFFE0, 16'h0000);
    cyc(1);
    rd("tcnt_t1", 16'hFFE0, 16'h0001);
    cyc(3);
    rd("tcnt_t2", 16'hFFE0, 16'h0002);
    cyc(3);
    rd("tcnt_wrap", 16'hFFE0, 16'h0000);
    rd("tctl_ready", 16'hFFE4, 16'h0003);
    cyc(9);
    rd("tcnt_wrap2", 16'hFFE0, 16'h0000);
    rd("tctl_ovr", 16'hFFE4, 16'h0007);

    // Ready set collides with its write-1-clear
    wr(16'hFFE4, 16'h0007);
    rd("tctl_cleared", 16'hFFE4, 16'h0001);
    cyc(7);
    wr(16'hFFE4, 16'h0003);
    rd("tctl_collide", 16'hFFE4, 16'h0003);
    rd("tcnt_collide", 16'hFFE0, 16'h0000);

    // TCNT write on a tick cycle
    cyc(2);
    wr(16'hFFE0, 16'h0005);
    rd("tcnt_wr_tick", 16'hFFE0, 16'h0005);
    cyc(3);
    rd("tcnt_after_wr", 16'hFFE0, 16'h0006);

    // Disable on a tick cycle suppresses it and freezes the timer
    cyc(2);
    wr(16'hFFE4, 16'h0000);
    rd("tcnt_suppr", 16'hFFE0, 16'h0006);
    rd("tctl_disabled", 16'hFFE4, 16'h0002);
    cyc(6);
    rd("tcnt_frozen", 16'hFFE0, 16'h0006);

    // Free-run wrap at 0xFFFF with no ready
    wr(16'hFFE2, 16'h0000);
    wr(16'hFFE0, 16'hFFFF);
    wr(16'hFFE4, 16'h0007);
    cyc(2);
    rd("free_pre", 16'hFFE0, 16'hFFFF);
    cyc(1);
    rd("free_wrap", 16'hFFE0, 16'h0000);
    rd("free_tctl", 16'hFFE4, 16'h0001);

    // Switch change, then reset during a debounce
    SW[9] = 1'b1;
    cyc(5);
    rd("sw_cyc5", 16'hFFF2, 16'h0000);
    cyc(1);
    rd("sw_cyc6", 16'hFFF2, 16'h0200);
    rd("sctrl_set", 16'hFFF6, 16'h0001);
    wr(16'hFFF6, 16'h0001);
    rd("sctrl_clr", 16'hFFF6, 16'h0000);
    SW[9] = 1'b0;
    cyc(3);
    RESET_N = 1'b0;
    #1;
    rd("rst_sctrl", 16'hFFF6, 16'h0000);
    rd("rst_sdata", 16'hFFF2, 16'h0000);
    check("rst2_hex", 32'(HEX), 32'h0);
    cyc(1);
    RESET_N = 1'b1;
    cyc(8);
    rd("post_sctrl", 16'hFFF6, 16'h0000);
    rd("post_sdata", 16'hFFF2, 16'h0000);
    rd("post_kctrl", 16'hFFF4, 16'h0000);
    rd("post_tcnt", 16'hFFE0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
